ldm_writeback_sequencer: RTL
============================

Name: ldm_writeback_sequencer

Overview:
Multi-register load sequencer for LDM (increment-after addressing). It accepts a 16-bit register list and a base address, then fetches one word per listed register through a valid/ready memory handshake. It drives the register file write port (WB_EN, DEST_WB, RESULT_WB) one register per accepted word, in ascending register order, with optional base-register writeback at the end. It sits between the memory stage and the register file write port; the hazard unit stalls the pipeline while busy is high.

Parameters:
ADDR_STEP, 4, byte increment between consecutive words
REG_COUNT, 16, number of architectural registers (list width; index width is log2 = 4)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a transfer; sampled only in IDLE
reg_list  input  16  bit i set = load register i; latched on accepted start
base_reg  input  4  base register index; latched on accepted start
base_value  input  32  base address; latched on accepted start
wb_base  input  1  base writeback requested; latched on accepted start
mem_addr  output  32  word address for the current fetch
mem_ready  output  1  sequencer ready to accept a data word
mem_valid  input  1  memory presents mem_data
mem_data  input  32  loaded word
WB_EN  output  1  register file write enable
DEST_WB  output  4  register file write index
RESULT_WB  output  32  register file write data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when transfer completes

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). On rst at a rising edge: state=IDLE; WB_EN=0, DEST_WB=0, RESULT_WB=0, mem_addr=0, done=0; internal list, pointer and count are cleared. rst overrides all other inputs, including mid-transfer: no further writes issue, and WB_EN is 0 from the reset edge on.
- Output timing: WB_EN, DEST_WB, RESULT_WB, mem_addr and done are registered. mem_ready and busy decode the current state. The register file samples on the falling edge, so write outputs are stable by then.
- States: IDLE, LOAD, BASE_WB, DONE.
- IDLE: mem_ready=0. If start=1, latch the inputs, set addr_ptr=base_value, set count=0, and clear the write outputs.
  - reg_list != 0: next state LOAD.
  - reg_list == 0: next state DONE. No loads and no base writeback occur.
- LOAD:
  - mem_ready=1. mem_addr=addr_ptr. cur = index of the lowest set bit in the remaining list.
  - On a handshake (mem_valid & mem_ready) at an edge: WB_EN<=1, DEST_WB<=cur, RESULT_WB<=mem_data. Clear bit cur, addr_ptr+=ADDR_STEP, count+=1.
  - If the remaining list becomes 0: go to BASE_WB if wb_base=1 and base_reg was not in the original list; otherwise go to DONE.
  - Without a handshake: WB_EN<=0 and hold.
  - Write latency: WB_EN is high in the cycle immediately after each handshake. Back-to-back handshakes give one write per cycle.
- BASE_WB: mem_ready=0. WB_EN<=1, DEST_WB<=base_reg, RESULT_WB<=base_value+ADDR_STEP*count (mod 2^32). Next state DONE.
- DONE: WB_EN<=0, done<=1 (high exactly one cycle, the cycle after leaving DONE). Next state IDLE.
- start outside IDLE is ignored. start is not accepted in the same cycle done is high, because that is the IDLE entry cycle's register update.
- Address arithmetic is 32-bit and wraps silently (0xFFFFFFFC + 4 = 0).
- Base register in the list: the loaded value wins and base writeback is suppressed.
- mem_data is ignored whenever mem_ready=0.

Test Plan:
- Reset defaults: assert rst 2 cycles -> WB_EN=0, busy=0, done=0, mem_ready=0, DEST_WB=0, RESULT_WB=0.
- Sparse list, back-to-back: start, reg_list=0x0025, base_value=0x100, wb_base=0, mem_valid=1 always, data 0xA,0xB,0xC -> mem_addr 0x100,0x104,0x108; writes (R0,0xA),(R2,0xB),(R5,0xC) on consecutive cycles; done one cycle later; busy drops.
- Stalled memory plus base writeback: reg_list=0x0003, base_reg=13, base_value=0x200, wb_base=1; mem_valid low 3 cycles, then pulses -> no WB_EN during the stall; writes (R0,d0),(R1,d1),(R13,0x208); done.
- Base in list: reg_list=0x2001, base_reg=13, wb_base=1 -> writes R0 then R13=loaded word; no 0x208-style base write; exactly 2 WB_EN pulses.
- Empty list and ignored start: reg_list=0 -> zero WB_EN pulses, done after 1 cycle. A start pulse mid-transfer -> no change to the write sequence.
- Reset mid-transfer: reg_list=0xFFFF, assert rst after 3 handshakes -> WB_EN=0 from the reset edge on, state IDLE. A new start after reset runs a clean transfer from its new base_value.

Source files
------------

// File: rtl/ldm_writeback_sequencer.sv
// LDM (increment-after) sequencer: fetches one word per listed register over a
// valid/ready handshake and drives the register file write port in ascending order.
module ldm_writeback_sequencer #(
  parameter int ADDR_STEP = 4,
  parameter int REG_COUNT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [REG_COUNT-1:0]         reg_list,
  input  logic [$clog2(REG_COUNT)-1:0] base_reg,
  input  logic [31:0]                  base_value,
  input  logic                         wb_base,
  output logic [31:0]                  mem_addr,
  output logic                         mem_ready,
  input  logic                         mem_valid,
  input  logic [31:0]                  mem_data,
  output logic                         WB_EN,
  output logic [$clog2(REG_COUNT)-1:0] DEST_WB,
  output logic [31:0]                  RESULT_WB,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int CNT_W = $clog2(REG_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    BASE_WB = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_q;
  logic [REG_COUNT-1:0] list_q;
  logic [REG_COUNT-1:0] orig_list_q;
  logic [IDX_W-1:0]     base_reg_q;
  logic [31:0]          base_value_q;
  logic                 wb_base_q;
  logic [31:0]          addr_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 wb_en_q;
  logic [IDX_W-1:0]     dest_q;
  logic [31:0]          result_q;
  logic                 done_q;

  logic [IDX_W-1:0]     cur_d;
  logic [REG_COUNT-1:0] list_d;
  logic                 handshake;

  // Downward scan so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    cur_d = '0;
    for (int i = REG_COUNT - 1; i >= 0; i--) begin
      if (list_q[i]) cur_d = IDX_W'(i);
    end
  end

  assign list_d    = list_q & (list_q - REG_COUNT'(1));
  assign mem_ready = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign handshake = mem_valid & mem_ready;

  assign mem_addr  = addr_ptr_q;
  assign WB_EN     = wb_en_q;
  assign DEST_WB   = dest_q;
  assign RESULT_WB = result_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      list_q       <= '0;
      orig_list_q  <= '0;
      base_reg_q   <= '0;
      base_value_q <= '0;
      wb_base_q    <= 1'b0;
      addr_ptr_q   <= '0;
      count_q      <= '0;
      wb_en_q      <= 1'b0;
      dest_q       <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_en_q <= 1'b0;
          done_q  <= 1'b0;
          // The cycle with done high is the IDLE entry cycle; a start there is dropped.
          if (start && !done_q) begin
            list_q       <= reg_list;
            orig_list_q  <= reg_list;
            base_reg_q   <= base_reg;
            base_value_q <= base_value;
            wb_base_q    <= wb_base;
            addr_ptr_q   <= base_value;
            count_q      <= '0;
            dest_q       <= '0;
            result_q     <= '0;
            state_q      <= (reg_list != '0) ? LOAD : DONE;
          end
        end
        LOAD: begin
          if (handshake) begin
            wb_en_q    <= 1'b1;
            dest_q     <= cur_d;
            result_q   <= mem_data;
            list_q     <= list_d;
            addr_ptr_q <= addr_ptr_q + 32'(ADDR_STEP);
            count_q    <= count_q + CNT_W'(1);
            // A base register that was itself loaded keeps the loaded value.
            if (list_d == '0) begin
              state_q <= (wb_base_q && !orig_list_q[base_reg_q]) ? BASE_WB : DONE;
            end
          end else begin
            wb_en_q <= 1'b0;
          end
        end
        BASE_WB: begin
          wb_en_q  <= 1'b1;
          dest_q   <= base_reg_q;
          result_q <= base_value_q + 32'(ADDR_STEP) * 32'(count_q);
          state_q  <= DONE;
        end
        DONE: begin
          wb_en_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          wb_en_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
